// File: rtl/operand_stage_pkg.sv
// Shared definitions for the execute-feed operand stage: datapath width,
// register-address width and the ALU control encodings.
package operand_stage_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned REG_AW    = $clog2(REG_COUNT);
    localparam int unsigned ALU_CTL_W = 3;

    typedef enum logic [ALU_CTL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_e;

endpackage

// File: rtl/regfile_2r1w.sv
// Two-read / one-write integer register file with x0 hardwired to zero.
// Same-cycle write-through bypass is enabled by defining OPERAND_STAGE_BYPASS_EN.
module regfile_2r1w
    import operand_stage_pkg::*;
#(
    parameter int unsigned XLEN       = operand_stage_pkg::XLEN,
    parameter int unsigned REG_COUNT  = operand_stage_pkg::REG_COUNT,
    parameter int unsigned RESET_REGS = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [$clog2(REG_COUNT)-1:0] raddr1,
    input  logic [$clog2(REG_COUNT)-1:0] raddr2,
    output logic [XLEN-1:0]              rdata1,
    output logic [XLEN-1:0]              rdata2,
    input  logic                         wb_en,
    input  logic [$clog2(REG_COUNT)-1:0] wb_addr,
    input  logic [XLEN-1:0]              wb_data
);

    logic [XLEN-1:0] regs [REG_COUNT];
    logic            wb_live;

    assign wb_live = wb_en && (wb_addr != '0);

    // Reset takes priority over a same-cycle writeback, even when the array is not cleared.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (RESET_REGS != 0) begin
                for (int unsigned i = 0; i < REG_COUNT; i++) begin
                    regs[i] <= '0;
                end
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
`ifdef OPERAND_STAGE_BYPASS_EN
        if (wb_live && (wb_addr == raddr1)) begin
            rdata1 = wb_data;
        end
`endif
    end

    always_comb begin
        rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];
`ifdef OPERAND_STAGE_BYPASS_EN
        if (wb_live && (wb_addr == raddr2)) begin
            rdata2 = wb_data;
        end
`endif
    end

endmodule

// File: rtl/operand_stage.sv
// Execute-feed stage: register-file read, SrcB select and a single-entry
// valid/ready slot driving the ALU. Optional bypass: OPERAND_STAGE_BYPASS_EN.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned XLEN       = operand_stage_pkg::XLEN,
    parameter int unsigned REG_COUNT  = operand_stage_pkg::REG_COUNT,
    parameter int unsigned RESET_REGS = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [$clog2(REG_COUNT)-1:0]           rs1,
    input  logic [$clog2(REG_COUNT)-1:0]           rs2,
    input  logic [$clog2(REG_COUNT)-1:0]           rd,
    input  logic [XLEN-1:0]                        imm,
    input  logic                                   alu_src,
    input  logic [operand_stage_pkg::ALU_CTL_W-1:0] alu_control_in,
    input  logic                                   reg_write_in,
    input  logic                                   flush,
    input  logic                                   wb_en,
    input  logic [$clog2(REG_COUNT)-1:0]           wb_addr,
    input  logic [XLEN-1:0]                        wb_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [XLEN-1:0]                        SrcA,
    output logic [XLEN-1:0]                        SrcB,
    output logic [operand_stage_pkg::ALU_CTL_W-1:0] ALUControl,
    output logic [$clog2(REG_COUNT)-1:0]           out_rd,
    output logic                                   out_reg_write
);

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] srcb_sel;
    logic            accept;

    regfile_2r1w #(
        .XLEN       (XLEN),
        .REG_COUNT  (REG_COUNT),
        .RESET_REGS (RESET_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr1  (rs1),
        .raddr2  (rs2),
        .rdata1  (rs1_data),
        .rdata2  (rs2_data),
        .wb_en   (wb_en),
        .wb_addr (wb_addr),
        .wb_data (wb_data)
    );

    assign in_ready = !out_valid || out_ready;
    // in_ready deliberately ignores flush; a flushed cycle simply never loads.
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        srcb_sel = alu_src ? imm : rs2_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid     <= 1'b0;
            SrcA          <= '0;
            SrcB          <= '0;
            ALUControl    <= '0;
            out_rd        <= '0;
            out_reg_write <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            SrcA          <= rs1_data;
            SrcB          <= srcb_sel;
            ALUControl    <= alu_control_in;
            out_rd        <= rd;
            out_reg_write <= reg_write_in;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Self-checking bench for operand_stage: directed steps followed by random
// traffic, compared against a behavioural model of the stage.
module tb_operand_stage;
    import operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        alu_src;
    logic [2:0]  alu_control_in;
    logic        reg_write_in;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] SrcA, SrcB;
    logic [2:0]  ALUControl;
    logic [4:0]  out_rd;
    logic        out_reg_write;

    always #5 clk = ~clk;

    operand_stage #(
        .XLEN       (32),
        .REG_COUNT  (32),
        .RESET_REGS (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .rs1            (rs1),
        .rs2            (rs2),
        .rd             (rd),
        .imm            (imm),
        .alu_src        (alu_src),
        .alu_control_in (alu_control_in),
        .reg_write_in   (reg_write_in),
        .flush          (flush),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .SrcA           (SrcA),
        .SrcB           (SrcB),
        .ALUControl     (ALUControl),
        .out_rd         (out_rd),
        .out_reg_write  (out_reg_write)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model: architectural register values plus the operation currently held.
    logic [31:0] m_rf [32];
    logic        m_valid;
    logic [31:0] m_a, m_b;
    logic [2:0]  m_ctl;
    logic [4:0]  m_rd;
    logic        m_rw;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef OPERAND_STAGE_BYPASS_EN
        if (wb_en && wb_addr == a) return wb_data;
`endif
        return m_rf[a];
    endfunction

    task automatic idle();
        reset          = 1'b0;
        in_valid       = 1'b0;
        rs1            = 5'd0;
        rs2            = 5'd0;
        rd             = 5'd0;
        imm            = 32'd0;
        alu_src        = 1'b0;
        alu_control_in = 3'd0;
        reg_write_in   = 1'b0;
        flush          = 1'b0;
        wb_en          = 1'b0;
        wb_addr        = 5'd0;
        wb_data        = 32'd0;
        out_ready      = 1'b1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en   = 1'b1;
        wb_addr = a;
        wb_data = d;
    endtask

    // One clock: check in_ready mid-cycle, advance the model at the edge,
    // then check every slot output shortly after the edge.
    task automatic cycle();
        logic        exp_ready, acc;
        logic [31:0] na, nb;
        @(negedge clk);
        exp_ready = !m_valid || out_ready;
        if (!$isunknown(exp_ready)) check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready && !flush;
        na  = m_read(rs1);
        nb  = alu_src ? imm : m_read(rs2);
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b0;
            m_a = 32'd0; m_b = 32'd0; m_ctl = 3'd0; m_rd = 5'd0; m_rw = 1'b0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            if (flush) m_valid = 1'b0;
            else if (acc) begin
                m_valid = 1'b1;
                m_a = na; m_b = nb; m_ctl = alu_control_in; m_rd = rd; m_rw = reg_write_in;
            end else if (out_ready) m_valid = 1'b0;
        end
        #1;
        check("out_valid",     32'(out_valid),     32'(m_valid));
        check("SrcA",          SrcA,               m_a);
        check("SrcB",          SrcB,               m_b);
        check("ALUControl",    32'(ALUControl),    32'(m_ctl));
        check("out_rd",        32'(out_rd),        32'(m_rd));
        check("out_reg_write", 32'(out_reg_write), 32'(m_rw));
    endtask

    initial begin
        m_valid = 1'bx;
        idle();

        // Reset overrides a same-cycle accept and writeback.
        reset = 1'b1; in_valid = 1'b1; rs1 = 5'd3; rd = 5'd4; reg_write_in = 1'b1;
        wb(5'd3, 32'hDEAD_BEEF);
        cycle();
        cycle();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_srca",  SrcA,           32'd0);
        check("rst_rd",    32'(out_rd),    32'd0);

        // Accept rs1=3, rs2=4 straight after reset: registers read as zero.
        idle();
        in_valid = 1'b1; rs1 = 5'd3; rs2 = 5'd4; alu_control_in = ALU_SUB; rd = 5'd9; reg_write_in = 1'b1;
        cycle();
        check("tp1_valid", 32'(out_valid), 32'd1);
        check("tp1_srca",  SrcA,           32'd0);
        check("tp1_srcb",  SrcB,           32'd0);
        idle();
        cycle();
        check("drain_valid", 32'(out_valid), 32'd0);

        // Writeback x5, then immediate operand.
        wb(5'd5, 32'h0000_00A5);
        cycle();
        idle();
        in_valid = 1'b1; rs1 = 5'd5; imm = 32'hFFFF_FFF0; alu_src = 1'b1; alu_control_in = ALU_ADD;
        cycle();
        check("tp2_srca", SrcA,              32'h0000_00A5);
        check("tp2_srcb", SrcB,              32'hFFFF_FFF0);
        check("tp2_ctl",  32'(ALUControl),   32'd0);

        // Writes to x0 are discarded.
        idle();
        wb(5'd0, 32'h0000_1234);
        cycle();
        idle();
        in_valid = 1'b1; rs1 = 5'd0;
        cycle();
        check("tp3_x0", SrcA, 32'd0);

        // Same-cycle writeback to a register being read.
        idle();
        wb(5'd7, 32'h11);
        cycle();
        idle();
        wb(5'd7, 32'h55);
        in_valid = 1'b1; rs1 = 5'd7; rs2 = 5'd7;
        cycle();
`ifdef OPERAND_STAGE_BYPASS_EN
        check("tp4_bypass", SrcA, 32'h55);
`else
        check("tp4_nobypass", SrcA, 32'h11);
`endif

        // Stall for three cycles with a held SrcA=0x10.
        idle();
        wb(5'd9, 32'h10);
        cycle();
        idle();
        in_valid = 1'b1; rs1 = 5'd9; rd = 5'd3;
        cycle();
        out_ready = 1'b0; rs1 = 5'd5; rd = 5'd12; alu_control_in = ALU_SLT;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_ready", 32'(in_ready),  32'd0);
            check("stall_srca",  SrcA,           32'h10);
            check("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cycle();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_srca",  SrcA,           32'hA5);
        check("b2b_rd",    32'(out_rd),    32'd12);

        // Flush a held slot while a new op is offered; the wb still lands.
        idle();
        flush = 1'b1; in_valid = 1'b1; rs1 = 5'd7; rd = 5'd21;
        wb(5'd10, 32'h77);
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_rd",    32'(out_rd),    32'd12);
        idle();
        cycle();
        check("flush_gone", 32'(out_valid), 32'd0);
        in_valid = 1'b1; rs1 = 5'd10;
        cycle();
        check("flush_wb", SrcA, 32'h77);

        // Reset while an operation is stalled discards it and clears registers.
        idle();
        out_ready = 1'b0; in_valid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("rst_held_valid", 32'(out_valid), 32'd0);
        idle();
        in_valid = 1'b1; rs1 = 5'd5;
        cycle();
        check("rst_cleared", SrcA, 32'd0);

        // Random traffic with narrow address ranges so hazards collide often.
        for (int n = 0; n < 600; n++) begin
            reset          = ($urandom_range(0, 99) == 0);
            in_valid       = $urandom_range(0, 3) != 0;
            rs1            = 5'($urandom_range(0, 7));
            rs2            = 5'($urandom_range(0, 7));
            rd             = 5'($urandom);
            imm            = $urandom;
            alu_src        = 1'($urandom);
            alu_control_in = 3'($urandom);
            reg_write_in   = 1'($urandom);
            flush          = ($urandom_range(0, 9) == 0);
            wb_en          = 1'($urandom);
            wb_addr        = 5'($urandom_range(0, 7));
            wb_data        = $urandom;
            out_ready      = $urandom_range(0, 2) != 0;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
Execute-feed stage sitting directly upstream of the ALU.
- Holds the 2-read/1-write integer register file.
- Selects SrcB from register rs2 or the immediate.
- Registers SrcA, SrcB and ALUControl into a single-entry valid/ready pipeline slot that drives the ALU inputs.
- Accepts writeback from downstream and handles stall and flush.

Parameters:
XLEN, 32, datapath and register width
REG_COUNT, 32, architectural registers; address width is clog2(REG_COUNT); x0 is hardwired to zero
RESET_REGS, 1, 1 = synchronous reset clears every register-file entry; 0 = reset clears only the pipeline slot

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  decode presents an operation
in_ready  out  1  stage can accept this cycle
rs1  in  5  source register A
rs2  in  5  source register B
rd  in  5  destination register, passed through
imm  in  XLEN  sign-extended immediate
alu_src  in  1  1 = SrcB takes imm; 0 = SrcB takes reg[rs2]
alu_control_in  in  3  ALU operation code, passed through
reg_write_in  in  1  passed through
flush  in  1  kill the held operation
wb_en  in  1  register-file write enable
wb_addr  in  5  write address
wb_data  in  XLEN  write data
out_valid  out  1  SrcA, SrcB and ALUControl are valid
out_ready  in  1  downstream accepts
SrcA  out  XLEN  ALU operand A
SrcB  out  XLEN  ALU operand B
ALUControl  out  3  ALU operation code
out_rd  out  5  destination register
out_reg_write  out  1  destination write enable

Behaviour:
- Reset, sampled at a rising edge:
  - out_valid=0; SrcA, SrcB, ALUControl, out_rd, out_reg_write = 0.
  - If RESET_REGS=1, all register-file entries become 0.
  - Reset overrides flush, accept and wb_en in the same cycle.
  - Reset during a held operation discards it.
- Register file:
  - Write on the rising edge when wb_en=1 and wb_addr!=0.
  - Writes to x0 are ignored.
  - Reads are combinational; reading x0 returns 0.
- in_ready = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Accept: when in_valid && in_ready, at the next edge:
  - SrcA <= read(rs1).
  - SrcB <= alu_src ? imm : read(rs2).
  - ALUControl, out_rd, out_reg_write are captured from their inputs.
  - out_valid <= 1.
  - Latency from accept to out_valid is 1 cycle.
- Drain: when out_valid && out_ready with no new accept, out_valid <= 0 at the next edge. Data outputs hold their last values.
- Stall: when out_valid && !out_ready, all outputs hold stable and in_ready=0.
- Flush:
  - At the next edge, out_valid <= 0.
  - Any same-cycle accept is dropped, even though in_ready may read 1 combinationally.
  - The register-file write in the same cycle still occurs.
- Simultaneous drain and accept: the new operation is loaded with out_valid staying 1, so back-to-back throughput is 1 op per cycle.
- Slot outputs are unaffected by wb to a register already captured; the captured value is final.
- ALUControl values are passed unchecked. Encoding: 000 add, 001 sub, 010 and, 011 or, 101 slt.

Optional Feature:
OPERAND_STAGE_BYPASS_EN
- Defined: same-cycle write-through bypass. If wb_en && wb_addr!=0 && wb_addr==rs1, read(rs1) returns wb_data; the same applies independently for rs2.
- Undefined: read(rs) returns the pre-write array value. A same-cycle writeback is not visible to an operation accepted in that cycle.

Decomposition:
- Shared package holds:
  - XLEN.
  - The register-address width constant.
  - ALU control encodings: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
- One sub-module, regfile_2r1w: array, x0 rule, optional bypass, RESET_REGS handling.
- The pipeline slot and SrcB mux live in operand_stage.

Test Plan:
- Reset with RESET_REGS=1, then accept rs1=3, rs2=4, alu_src=0 -> out_valid=1 one cycle later, SrcA=0, SrcB=0.
- wb x5=0x0000_00A5, then accept rs1=5, imm=0xFFFF_FFF0, alu_src=1, alu_control_in=000 -> SrcA=0x0000_00A5, SrcB=0xFFFF_FFF0, ALUControl=000.
- wb x0=0x1234 then read rs1=0 -> SrcA=0.
- Same-cycle wb x7=0x55 and accept rs1=7, where x7 was previously 0x11 -> SrcA=0x55 with OPERAND_STAGE_BYPASS_EN defined; SrcA=0x11 without it.
- out_ready=0 for 3 cycles with op held (SrcA=0x10) -> in_ready=0, outputs stable at 0x10 throughout; out_ready=1 with in_valid=1 -> next op loaded, out_valid stays 1.
- flush=1 together with in_valid=1 while a slot is held -> out_valid=0 next cycle, and the flushed input operation never appears.
